// File: rtl/lcd_pkg.sv
// Shared types, command codes and default timing for the HD44780 bus driver.
package lcd_pkg;

  typedef enum logic [3:0] {
    StPowerup,
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StWait,
    StPSetup,
    StPStrobe,
    StPHold
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
  // Return-home ignores bit 0, so 8'h03 is also a home command.
  localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

  localparam int unsigned LCD_DEF_POWERUP_CYCLES = 15000;
  localparam int unsigned LCD_DEF_SETUP_CYCLES   = 1;
  localparam int unsigned LCD_DEF_E_HIGH_CYCLES  = 1;
  localparam int unsigned LCD_DEF_HOLD_CYCLES    = 1;
  localparam int unsigned LCD_DEF_EXEC_CYCLES    = 40;
  localparam int unsigned LCD_DEF_CLEAR_CYCLES   = 1600;

  // Clear and home need the long execution wait; data writes never do.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME) ||
                   (data == LCD_CMD_HOME_ALT));
  endfunction

  function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter shared by every timed phase of the bus driver.
module lcd_delay_counter #(
  parameter int unsigned     Width    = 8,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= ResetVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780-compatible 8-bit parallel bus driver with cycle-timed phases.
// Optional macro LCD_BUSY_POLL_EN replaces the fixed execution wait with
// busy-flag polling over the DB bus.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = LCD_DEF_POWERUP_CYCLES,
  parameter int unsigned SETUP_CYCLES   = LCD_DEF_SETUP_CYCLES,
  parameter int unsigned E_HIGH_CYCLES  = LCD_DEF_E_HIGH_CYCLES,
  parameter int unsigned HOLD_CYCLES    = LCD_DEF_HOLD_CYCLES,
  parameter int unsigned EXEC_CYCLES    = LCD_DEF_EXEC_CYCLES,
  parameter int unsigned CLEAR_CYCLES   = LCD_DEF_CLEAR_CYCLES
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       RS,
  output logic       RnW,
  output logic       E,
  output logic [7:0] DB_Out,
  input  logic [7:0] DB_In,
  output logic       DB_nEnable,
  output logic       busy
);

  localparam int unsigned MaxCycles =
      max_cycles(max_cycles(max_cycles(POWERUP_CYCLES, SETUP_CYCLES),
                            max_cycles(E_HIGH_CYCLES, HOLD_CYCLES)),
                 max_cycles(EXEC_CYCLES, CLEAR_CYCLES));
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  lcd_state_t state_q, state_d;

  logic            cnt_load;
  logic [CntW-1:0] cnt_load_val;
  logic            cnt_zero;

  logic       rs_q, rs_d;
  logic       rnw_q, rnw_d;
  logic       e_q, e_d;
  logic [7:0] db_out_q, db_out_d;
  logic       db_nen_q, db_nen_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;

`ifdef LCD_BUSY_POLL_EN
  logic bf_q;
  logic unused_db_in;
  assign unused_db_in = ^DB_In[6:0];
`else
  logic unused_db_in;
  assign unused_db_in = ^DB_In;
`endif

  // Reset value covers the first power-up phase, which has no entry edge.
  lcd_delay_counter #(
    .Width    (CntW),
    .ResetVal (CntW'(POWERUP_CYCLES - 1))
  ) u_delay (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StPowerup;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each timed phase ends on the edge that sees the counter at zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StPowerup: if (cnt_zero) state_d = StIdle;
      StIdle:    if (req_valid && ready_q) state_d = StSetup;
      StSetup:   if (cnt_zero) state_d = StStrobe;
      StStrobe:  if (cnt_zero) state_d = StHold;
`ifdef LCD_BUSY_POLL_EN
      StHold:    if (cnt_zero) state_d = StPSetup;
      StPSetup:  if (cnt_zero) state_d = StPStrobe;
      StPStrobe: if (cnt_zero) state_d = StPHold;
      StPHold:   if (cnt_zero) state_d = bf_q ? StPSetup : StIdle;
`else
      StHold:    if (cnt_zero) state_d = StWait;
      StWait:    if (cnt_zero) state_d = StIdle;
`endif
      default:   state_d = StPowerup;
    endcase
  end

  // Reload the counter with N-1 on every phase entry.
  always_comb begin
    cnt_load = (state_d != state_q);
    case (state_d)
      StSetup, StPSetup:   cnt_load_val = CntW'(SETUP_CYCLES - 1);
      StStrobe, StPStrobe: cnt_load_val = CntW'(E_HIGH_CYCLES - 1);
      StHold, StPHold:     cnt_load_val = CntW'(HOLD_CYCLES - 1);
      StWait:              cnt_load_val = is_long_cmd(rs_q, db_out_q) ?
                                          CntW'(CLEAR_CYCLES - 1) :
                                          CntW'(EXEC_CYCLES - 1);
      default:             cnt_load_val = '0;
    endcase
  end

  // Output next-values; all pins are registered so they change only on edges.
  always_comb begin
    rs_d     = rs_q;
    rnw_d    = rnw_q;
    db_out_d = db_out_q;
    db_nen_d = db_nen_q;
    if ((state_q == StIdle) && (state_d == StSetup)) begin
      rs_d     = req_rs;
      db_out_d = req_data;
      rnw_d    = 1'b0;
    end
`ifdef LCD_BUSY_POLL_EN
    // Each poll reads the busy flag from the instruction register.
    if ((state_d == StPSetup) && (state_q != StPSetup)) begin
      rs_d     = 1'b0;
      rnw_d    = 1'b1;
      db_nen_d = 1'b1;
    end
    if ((state_q == StPHold) && (state_d == StIdle)) begin
      rnw_d    = 1'b0;
      db_nen_d = 1'b0;
    end
`endif
    e_d     = (state_d == StStrobe) || (state_d == StPStrobe);
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
  end

  // Output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rs_q     <= 1'b0;
      rnw_q    <= 1'b0;
      e_q      <= 1'b0;
      db_out_q <= 8'h00;
      db_nen_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      rs_q     <= rs_d;
      rnw_q    <= rnw_d;
      e_q      <= e_d;
      db_out_q <= db_out_d;
      db_nen_q <= db_nen_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

`ifdef LCD_BUSY_POLL_EN
  // Capture the busy flag on the last edge of the read strobe.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bf_q <= 1'b0;
    end else if ((state_q == StPStrobe) && cnt_zero) begin
      bf_q <= DB_In[7];
    end
  end
`endif

  assign RS         = rs_q;
  assign RnW        = rnw_q;
  assign E          = e_q;
  assign DB_Out     = db_out_q;
  assign DB_nEnable = db_nen_q;
  assign req_ready  = ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with small timing parameters.
module tb_lcd_bus_driver;

  localparam int unsigned PowerupCycles = 20;
`ifdef LCD_BUSY_POLL_EN
  // One poll (S+E+H = 8) replaces the fixed wait; strobes include the read.
  localparam int ShortRdy = 16;
  localparam int LongRdy  = 16;
  localparam int ECnt     = 8;
  localparam int RsStable = 8;
`else
  localparam int ShortRdy = 18;
  localparam int LongRdy  = 58;
  localparam int ECnt     = 4;
  localparam int RsStable = 1000;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;
  logic       RS;
  logic       RnW;
  logic       E;
  logic [7:0] DB_Out;
  logic [7:0] DB_In;
  logic       DB_nEnable;
  logic       busy;

  int tests = 0;
  int fails = 0;

  lcd_bus_driver #(
    .POWERUP_CYCLES (20),
    .SETUP_CYCLES   (2),
    .E_HIGH_CYCLES  (4),
    .HOLD_CYCLES    (2),
    .EXEC_CYCLES    (10),
    .CLEAR_CYCLES   (50)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs     (req_rs),
    .req_data   (req_data),
    .RS         (RS),
    .RnW        (RnW),
    .E          (E),
    .DB_Out     (DB_Out),
    .DB_In      (DB_In),
    .DB_nEnable (DB_nEnable),
    .busy       (busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Called just after reset release; edge 1 is the next rising edge.
  task automatic check_powerup(input string tag);
    bit low_ok = 1'b1;
    for (int i = 1; i < int'(PowerupCycles); i++) begin
      tick();
      if (req_ready !== 1'b0 || busy !== 1'b1 || E !== 1'b0) low_ok = 1'b0;
    end
    chk({tag, " ready low during powerup"}, 32'(low_ok), 32'd1);
    tick();
    chk({tag, " ready at powerup end"}, 32'(req_ready), 32'd1);
    chk({tag, " busy at powerup end"}, 32'(busy), 32'd0);
  endtask

  // Issue one byte and measure E timing and ready return, relative to the accept edge.
  task automatic run_xfer(input logic rs, input logic [7:0] data, input bit hold_valid,
                          input int pulse_at, input int exp_rdy, input string tag);
    int e_rise = -1;
    int e_cnt  = 0;
    int rdy    = -1;
    bit stable = 1'b1;
    req_rs    = rs;
    req_data  = data;
    req_valid = 1'b1;
    tick();
    chk({tag, " accept"}, {21'd0, req_ready, busy, RS, DB_Out}, {21'd0, 1'b0, 1'b1, rs, data});
    req_rs   = ~rs;
    req_data = ~data;
    if (!hold_valid) req_valid = 1'b0;
    for (int off = 1; off <= 200; off++) begin
      if (pulse_at > 0 && off == pulse_at) req_valid = 1'b1;
      if (pulse_at > 0 && off == pulse_at + 1) req_valid = 1'b0;
      tick();
      if (E === 1'b1 && e_rise < 0) e_rise = off;
      if (E === 1'b1) e_cnt++;
      if (DB_Out !== data || (RS !== rs && off < RsStable)) stable = 1'b0;
      if (req_ready === 1'b1) begin
        rdy = off;
        break;
      end
    end
    chk({tag, " E rise offset"}, 32'(e_rise), 32'd2);
    chk({tag, " E high cycles"}, 32'(e_cnt), 32'(ECnt));
    chk({tag, " ready return"}, 32'(rdy), 32'(exp_rdy));
    chk({tag, " RS/DB stable"}, 32'(stable), 32'd1);
  endtask

  // Idle with no request: no strobe, ready stays high, last byte stays on the bus.
  task automatic idle_watch(input int n, input logic [7:0] exp_db, input string tag);
    bit ok = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (E !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || DB_Out !== exp_db) ok = 1'b0;
    end
    chk({tag, " idle quiet"}, 32'(ok), 32'd1);
  endtask

  initial begin
    Reset     = 1'b1;
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h41;
    DB_In     = 8'h00;
    #3;
    chk("reset RS", 32'(RS), 32'd0);
    chk("reset RnW", 32'(RnW), 32'd0);
    chk("reset E", 32'(E), 32'd0);
    chk("reset DB_Out", 32'(DB_Out), 32'd0);
    chk("reset DB_nEnable", 32'(DB_nEnable), 32'd0);
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd1);
    tick();
    Reset = 1'b0;

    // Request held valid through power-up is accepted on edge 21.
    check_powerup("boot");
    run_xfer(1'b1, 8'h41, 1'b0, 0, ShortRdy, "data41");
    idle_watch(3, 8'h41, "after41");

    run_xfer(1'b0, 8'h01, 1'b0, 0, LongRdy, "clear");
    run_xfer(1'b0, 8'h38, 1'b0, 0, ShortRdy, "func38");
    run_xfer(1'b0, 8'h00, 1'b0, 0, ShortRdy, "cmd00");
    run_xfer(1'b0, 8'h02, 1'b0, 0, LongRdy, "home02");
    run_xfer(1'b0, 8'h03, 1'b0, 0, LongRdy, "home03");
    run_xfer(1'b1, 8'h01, 1'b0, 0, ShortRdy, "data01");
    run_xfer(1'b0, 8'h04, 1'b0, 0, ShortRdy, "cmd04");

    // Back-to-back with valid held: second accept on the edge after ready returns.
    run_xfer(1'b1, 8'h61, 1'b1, 0, ShortRdy, "b2b first");
    run_xfer(1'b1, 8'h62, 1'b0, 0, ShortRdy, "b2b second");
    idle_watch(30, 8'h62, "after b2b");

    // One-cycle request pulse during the wait phase must be dropped.
    run_xfer(1'b0, 8'h38, 1'b0, 12, ShortRdy, "pulse");
    idle_watch(30, 8'h38, "after pulse");

    // Reset in the middle of the E strobe.
    req_rs    = 1'b1;
    req_data  = 8'h55;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("midreset E before", 32'(E), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("midreset E async", 32'(E), 32'd0);
    chk("midreset RS async", 32'(RS), 32'd0);
    chk("midreset DB async", 32'(DB_Out), 32'd0);
    chk("midreset ready", 32'(req_ready), 32'd0);
    tick();
    Reset = 1'b0;
    check_powerup("reboot");
    run_xfer(1'b1, 8'h5a, 1'b0, 0, ShortRdy, "after reboot");

`ifdef LCD_BUSY_POLL_EN
    begin
      int  rd    = 0;
      int  rdy   = -1;
      bit  bad   = 1'b0;
      logic prev_e = 1'b0;
      DB_In     = 8'h80;
      req_rs    = 1'b0;
      req_data  = 8'h01;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int off = 1; off <= 300; off++) begin
        tick();
        if (E === 1'b1 && prev_e === 1'b0 && RnW === 1'b1) rd++;
        if (E === 1'b1 && RnW === 1'b1 && DB_nEnable !== 1'b1) bad = 1'b1;
        if (rd >= 3) DB_In = 8'h00;
        prev_e = E;
        if (req_ready === 1'b1) begin
          rdy = off;
          break;
        end
      end
      chk("poll read strobes", 32'(rd), 32'd3);
      chk("poll pads released", 32'(bad), 32'd0);
      chk("poll ready offset", 32'(rdy), 32'd32);
      chk("poll RnW restored", 32'(RnW), 32'd0);
      chk("poll nEnable restored", 32'(DB_nEnable), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_bus_driver.md
# lcd_bus_driver

- Cycle-timed HD44780-compatible 8-bit parallel bus driver.
- Sits between the SoC's display peripheral and the LCD pads: consumes byte-write requests (register select + data) over a valid/ready handshake and produces RS, RnW, E and the bidirectional DB bus.
- Enforces power-up delay, address setup, E pulse width, hold and command execution time, so the SoC only issues bytes.

## Interface
Parameters:
- POWERUP_CYCLES, 15000, post-reset delay before first request is accepted
- SETUP_CYCLES, 1, RS/RnW/DB stable before E rises (min 1)
- E_HIGH_CYCLES, 1, E pulse width (min 1)
- HOLD_CYCLES, 1, RS/RnW/DB held after E falls (min 1)
- EXEC_CYCLES, 40, wait after ordinary command/data write
- CLEAR_CYCLES, 1600, wait after clear/home command

Ports:
- Clock  input  1  system clock
- Reset  input  1  asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  driver can accept
- req_rs  input  1  0 = command, 1 = data
- req_data  input  8  byte to write
- RS  output  1  LCD register select
- RnW  output  1  LCD read/not-write
- E  output  1  LCD enable strobe
- DB_Out  output  8  bus drive value
- DB_In  input  8  bus read value
- DB_nEnable  output  1  0 = pads drive DB_Out, 1 = pads tristate
- busy  output  1  high whenever not in IDLE

## Operation
- States: POWERUP, IDLE, SETUP, STROBE, HOLD, WAIT; with polling also P_SETUP, P_STROBE, P_HOLD.
- All outputs registered. Reset values:
  - RS=0, RnW=0, E=0, DB_Out=8'h00, DB_nEnable=0.
  - req_ready=0, busy=1, state=POWERUP, counter loaded with POWERUP_CYCLES.
- POWERUP: counts POWERUP_CYCLES cycles, then IDLE.
- IDLE: req_ready=1, busy=0. Handshake: the transfer occurs on an edge where req_valid && req_ready.
  - At that edge: RS<=req_rs, DB_Out<=req_data, RnW<=0, req_ready<=0, busy<=1, go to SETUP.
  - req_data/req_rs are ignored after acceptance.
- SETUP, STROBE, HOLD last exactly SETUP_CYCLES, E_HIGH_CYCLES, HOLD_CYCLES cycles. E=1 only in STROBE. RS/DB_Out are unchanged throughout.
- Long command: RS=0 and DB_Out in {8'h01, 8'h02, 8'h03}. WAIT lasts CLEAR_CYCLES for long commands, EXEC_CYCLES otherwise (including 8'h00).
- WAIT then IDLE. RS/DB_Out keep their last values in IDLE.
- req_valid may rise or fall at any time. It has no effect outside IDLE, and there is no queueing.
- Counter: single down-counter, width $clog2(max parameter + 1). Load N-1 on phase entry; advance phase when counter is 0 on a clock edge.
- Reset mid-operation: E drops to 0 asynchronously and the whole power-up sequence is repeated.

## Timing
- Accepted at edge k (no polling):
  - E rises at k+SETUP_CYCLES and falls at k+SETUP_CYCLES+E_HIGH_CYCLES.
  - req_ready returns high at k+S+E+H+W, where W = EXEC_CYCLES or CLEAR_CYCLES.
- Back-to-back throughput: one byte per S+E+H+W cycles. A request held valid on the re-entry edge into IDLE is accepted on the following edge, giving 1 idle cycle minimum.
- First accept possible at edge POWERUP_CYCLES+1 after reset release.

## Configuration
- LCD_BUSY_POLL_EN defined: WAIT is replaced by busy-flag polling. After HOLD:
  - P_SETUP: DB_nEnable=1, RnW=1, RS=0, for SETUP_CYCLES.
  - P_STROBE: E=1 for E_HIGH_CYCLES; DB_In[7] is sampled on the last P_STROBE edge.
  - P_HOLD: HOLD_CYCLES.
  - If the sampled bit is 1, repeat P_SETUP. If 0, restore RnW=0 and DB_nEnable=0, then go to IDLE.
  - EXEC_CYCLES and CLEAR_CYCLES are unused.
  - No timeout: DB_In[7] stuck high stalls indefinitely with busy=1.
- Macro undefined: RnW and DB_nEnable are constant 0 after reset, DB_In is unused, and the fixed WAIT is used.

## Structure
- Package lcd_pkg holds:
  - state enum lcd_state_t
  - LCD_CMD_CLEAR=8'h01 and LCD_CMD_HOME=8'h02
  - default timing constants
  - function is_long_cmd(rs, data)
- Sub-module lcd_delay_counter: loadable down-counter with load value input, load strobe and zero flag, parameterised width. It is reused for every phase.

## Test plan
Parameters for all scenarios: POWERUP=20, SETUP=2, E_HIGH=4, HOLD=2, EXEC=10, CLEAR=50.
- Reset then req_valid held high with rs=1, data=8'h41 -> req_ready low for 20 cycles. Accept at edge 21. E high at edges 23–26. RS=1 and DB_Out=8'h41 stable from 21 to the next accept. req_ready high again 18 cycles after accept.
- Command 8'h01 -> req_ready returns 58 cycles after accept. Command 8'h38 -> 18 cycles. Command 8'h00 -> 18 cycles.
- Two back-to-back requests with req_valid continuously high -> exactly one E pulse each, each 4 cycles wide. Second DB_Out value appears only after the first wait completes. No request lost or duplicated.
- Reset asserted while E=1 mid-STROBE -> E, RS, DB_Out go 0 before the next edge. req_ready stays low for 20 cycles after release.
- LCD_BUSY_POLL_EN with DB_In[7]=1 for two polls, then 0:
  - exactly three read strobes with RnW=1 and DB_nEnable=1
  - then req_ready=1, RnW=0, DB_nEnable=0
- Request pulsed high for one cycle during WAIT -> ignored. No E pulse follows it.
